p1_handed: RTL and testbench
============================

P1_HANDED -- requirements
Module: p1_handed

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the handover counter.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The module SHALL have port state, input, 3 bits, the encoded game phase from the top-level game FSM.
REQ-005 The module SHALL have port p1handed, output, 1 bit, high while player 1 holds the hand.
REQ-006 The module SHALL have port p2handed, output, 1 bit, high while player 2 holds the hand.
REQ-007 The module SHALL have port handover, output, 1 bit, a one-cycle pulse when ownership moves directly between players.
REQ-008 The module SHALL have port illegal, output, 1 bit, high for each cycle after state was sampled as the reserved code.
REQ-009 The module SHALL have port handover_cnt, output, CNT_W bits, the count of handovers since reset.

Function
REQ-010 The state encoding SHALL be: 000 IDLE, 001 P1_TURN, 010 P1_ACTION, 011 P2_TURN, 100 P2_ACTION, 101 RESOLVE, 110 GAME_OVER, 111 RESERVED.
REQ-011 An internal owner register SHALL hold one of NONE, P1 or P2.
REQ-012 Owner SHALL update on each clock edge from the sampled state:
- P1_TURN or P1_ACTION -> P1
- P2_TURN or P2_ACTION -> P2
- IDLE or GAME_OVER -> NONE
- RESOLVE -> hold current value
- RESERVED -> hold current value
REQ-013 p1handed SHALL equal (owner==P1) and p2handed SHALL equal (owner==P2), both registered, so latency from state to output is exactly 1 cycle.
REQ-014 p1handed and p2handed SHALL never be high together.
REQ-015 handover SHALL be high for exactly the cycle after owner changes P1->P2 or P2->P1; changes from or to NONE SHALL NOT pulse.
REQ-016 illegal SHALL be high in the cycle after RESERVED is sampled and low otherwise; it is not sticky.
REQ-017 handover_cnt SHALL increment by 1 on each handover event and saturate at 2^CNT_W-1 (no wrap).
REQ-018 Repeated samples of the same player state SHALL neither pulse handover nor change the count.

Reset
REQ-019 While rst_n is low at a clock edge, the block SHALL set:
- owner=NONE
- p1handed=0
- p2handed=0
- handover=0
- illegal=0
- handover_cnt=0
REQ-020 Reset SHALL take priority over any state value, including reset asserted mid-game; state is ignored during that cycle.
REQ-021 Outputs before the first reset edge SHALL be don't-care.

Configuration
REQ-022 With macro P1_HANDED_HANDOVER_CNT_EN defined, the counter of REQ-017 SHALL be implemented.
REQ-023 Without P1_HANDED_HANDOVER_CNT_EN, handover_cnt SHALL be tied to 0 with no counter flops; all other behaviour is unchanged.

Structure
REQ-024 A shared package p1_handed_pkg SHALL hold:
- the game_state_e typedef (3-bit encodings of REQ-010)
- the owner_e typedef (NONE=00, P1=01, P2=10)
- the default CNT_W constant
REQ-025 The saturating counter SHALL be one sub-module, sat_counter, parameterised by width with inputs clk, rst_n, inc; the rest SHALL be flat in p1_handed.

Verification
REQ-026 Reset then hold state=000 for 3 cycles -> p1handed=0, p2handed=0, handover_cnt=0.
REQ-027 Sweep state 000..111, one per cycle -> p1handed=1 only after 001 and 010 (and after the 101 that follows 100 it stays 0); p2handed=1 after 011, 100, 101; illegal=1 only after 111.
REQ-028 Sequence 001,011,001,011 -> handover pulses 3 times, handover_cnt=3, p1handed/p2handed alternate 1 cycle late.
REQ-029 Sequence 001,101,101,111 -> p1handed stays 1 throughout; illegal=1 one cycle after 111.
REQ-030 Set CNT_W=2 and drive 6 alternating handovers -> handover_cnt saturates at 3; rst_n=0 mid-sequence -> all outputs 0 the next cycle.
REQ-031 Build without P1_HANDED_HANDOVER_CNT_EN and rerun REQ-028 -> handover_cnt=0 with identical handover pulses.

Source files
------------

// File: rtl/p1_handed_pkg.sv
// Shared game-phase and hand-ownership types for the p1_handed hand tracker.
package p1_handed_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        P1_TURN   = 3'b001,
        P1_ACTION = 3'b010,
        P2_TURN   = 3'b011,
        P2_ACTION = 3'b100,
        RESOLVE   = 3'b101,
        GAME_OVER = 3'b110,
        RESERVED  = 3'b111
    } game_state_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10
    } owner_e;

    // Ownership implied by a game phase; RESOLVE and RESERVED keep the current owner.
    function automatic owner_e next_owner(input game_state_e st, input owner_e cur);
        owner_e nxt;
        nxt = cur;
        case (st)
            P1_TURN, P1_ACTION: nxt = P1;
            P2_TURN, P2_ACTION: nxt = P2;
            IDLE, GAME_OVER:    nxt = NONE;
            default:            nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/p1_handed_sat.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, synchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/p1_handed.sv
// Tracks which player holds the hand from the game FSM phase, flags direct handovers.
// Define P1_HANDED_HANDOVER_CNT_EN to build the saturating handover counter.
module p1_handed
    import p1_handed_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       state,
    output logic             p1handed,
    output logic             p2handed,
    output logic             handover,
    output logic             illegal,
    output logic [CNT_W-1:0] handover_cnt
);

    owner_e      owner;
    owner_e      owner_d;
    game_state_e st;
    logic        handover_d;

    // Next owner and direct player-to-player transfer detection
    always_comb begin
        st         = game_state_e'(state);
        owner_d    = next_owner(st, owner);
        handover_d = ((owner == P1) && (owner_d == P2)) ||
                     ((owner == P2) && (owner_d == P1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner    <= NONE;
            p1handed <= 1'b0;
            p2handed <= 1'b0;
            handover <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            owner    <= owner_d;
            p1handed <= (owner_d == P1);
            p2handed <= (owner_d == P2);
            handover <= handover_d;
            illegal  <= (st == RESERVED);
        end
    end

`ifdef P1_HANDED_HANDOVER_CNT_EN
    // Count advances on the same edge that raises the handover pulse
    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (handover_d),
        .cnt   (handover_cnt)
    );
`else
    assign handover_cnt = '0;
`endif

endmodule

// File: tb/tb_p1_handed.sv
// Self-checking bench for p1_handed: directed vector table plus randomized phases vs a reference model.
module tb_p1_handed;

    logic       clk;
    logic       rst_n;
    logic [2:0] state;

    logic       p1handed, p2handed, handover, illegal;
    logic [7:0] handover_cnt;
    logic       p1handed_s, p2handed_s, handover_s, illegal_s;
    logic [1:0] handover_cnt_s;

    int vectors;
    int miscompares;

    // Reference model: owner 0=none, 1=player1, 2=player2; count unbounded
    int m_own;
    int m_ho;
    int m_ill;
    int m_cnt;

    typedef struct {
        logic       rst_n;
        logic [2:0] st;
        logic       p1;
        logic       p2;
        logic       ho;
        logic       ill;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    p1_handed dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .p1handed     (p1handed),
        .p2handed     (p2handed),
        .handover     (handover),
        .illegal      (illegal),
        .handover_cnt (handover_cnt)
    );

    p1_handed #(.CNT_W(2)) dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .p1handed     (p1handed_s),
        .p2handed     (p2handed_s),
        .handover     (handover_s),
        .illegal      (illegal_s),
        .handover_cnt (handover_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_cnt(input int raw, input int maxv);
`ifdef P1_HANDED_HANDOVER_CNT_EN
        return (raw > maxv) ? maxv : raw;
`else
        return 0 * raw * maxv;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [2:0] s);
        int nown;
        if (!r) begin
            m_own = 0; m_ho = 0; m_ill = 0; m_cnt = 0;
        end else begin
            if (s == 3'd1 || s == 3'd2)      nown = 1;
            else if (s == 3'd3 || s == 3'd4) nown = 2;
            else if (s == 3'd0 || s == 3'd6) nown = 0;
            else                             nown = m_own;
            m_ho  = ((m_own == 1 && nown == 2) || (m_own == 2 && nown == 1)) ? 1 : 0;
            m_ill = (s == 3'd7) ? 1 : 0;
            m_cnt = m_cnt + m_ho;
            m_own = nown;
        end
    endtask

    // Drive one cycle, advance the model, then compare both instances after the edge
    task automatic apply(input logic r, input logic [2:0] s);
        @(negedge clk);
        rst_n = r;
        state = s;
        model_step(r, s);
        @(posedge clk);
        #1;
        check("flags", 32'({p1handed, p2handed, handover, illegal}),
              32'({m_own == 1, m_own == 2, m_ho == 1, m_ill == 1}));
        check("cnt", 32'(handover_cnt), 32'(exp_cnt(m_cnt, 255)));
        check("flags_w2", 32'({p1handed_s, p2handed_s, handover_s, illegal_s}),
              32'({m_own == 1, m_own == 2, m_ho == 1, m_ill == 1}));
        check("cnt_w2", 32'(handover_cnt_s), 32'(exp_cnt(m_cnt, 3)));
        check("exclusive", 32'(p1handed & p2handed), 32'(0));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_own = 0; m_ho = 0; m_ill = 0; m_cnt = 0;
        rst_n = 1'b0;
        state = 3'd0;

        // {rst_n, state, p1, p2, handover, illegal, raw handover count}
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 6});
        vecs.push_back('{1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0});

        foreach (vecs[i]) begin
            apply(vecs[i].rst_n, vecs[i].st);
            check($sformatf("vec%0d", i),
                  32'({p1handed, p2handed, handover, illegal}),
                  32'({vecs[i].p1, vecs[i].p2, vecs[i].ho, vecs[i].ill}));
            check($sformatf("vec%0d_cnt", i), 32'(handover_cnt), 32'(exp_cnt(vecs[i].cnt, 255)));
            check($sformatf("vec%0d_cnt_w2", i), 32'(handover_cnt_s), 32'(exp_cnt(vecs[i].cnt, 3)));
        end

        // Long alternating run to push the wide counter past small values
        for (int k = 0; k < 300; k++) begin
            apply(1'b1, (k % 2 == 0) ? 3'd2 : 3'd4);
        end

        // Random phases with occasional resets
        for (int k = 0; k < 2000; k++) begin
            apply(($urandom_range(0, 49) != 0), 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
